sprite_layer_mux: RTL
=====================

// Module: sprite_layer_mux
// PURPOSE
//  N-layer pixel compositor between the per-sprite generators (sprite, one per object) and color_mapper.
//  Replaces the single hard-coded "drawing ? sprite_pix : bg" select with a parametrised priority mux.
//  Adds transparency handling, per-layer enables and per-frame collision flags for game logic.
//  Collisions cover ship/invader, bullet/invader and similar.
//  Runs in the clk_pix domain; output feeds color_mapper one cycle later.
// PARAMETERS
//  NUM_LAYERS   4    number of sprite layers; index 0 = highest priority; legal 1..8
//  PIX_W        4    bits per color code
//  TRANSPARENT  0    color code treated as see-through even when layer_drawing=1
// PORTS
//  clk_pix         in   1                  pixel clock (25 MHz)
//  rst             in   1                  asynchronous, active-high reset
//  frame           in   1                  1-cycle pulse from display_480p at start of each frame
//  de              in   1                  visible-region flag from display_480p
//  layer_en        in   NUM_LAYERS         per-layer enable; 0 = layer ignored entirely
//  layer_drawing   in   NUM_LAYERS         per-layer "sprite covers this pixel" flag
//  layer_pix       in   NUM_LAYERS*PIX_W   layer i color code at bits [i*PIX_W +: PIX_W]
//  bg_pix          in   PIX_W              background color code
//  screen_pix      out  PIX_W              composited color code, registered
//  screen_layer    out  $clog2(NUM_LAYERS+1)  winning layer index; NUM_LAYERS = background
//  collision_mask  out  NUM_LAYERS         layer i overlapped another opaque layer in last frame
//  collision_valid out  1                  1-cycle pulse: collision_mask updated
// BEHAVIOUR
//  - Layer i is opaque at a pixel iff layer_en[i] & layer_drawing[i] & (layer_pix[i] != TRANSPARENT).
//  - Winner = lowest-index opaque layer. screen_pix = its pix and screen_layer = i.
//    With no opaque layer: screen_pix = bg_pix, screen_layer = NUM_LAYERS.
//  - Latency: exactly 1 clk_pix from inputs to screen_pix/screen_layer, regardless of de.
//    The caller blanks outside de.
//  - Collision accumulator acc[NUM_LAYERS] (internal):
//    on a cycle with de=1 and >=2 opaque layers, acc[i] |= opaque[i] for every opaque i.
//    Outside de nothing accumulates; transparent or disabled layers never collide.
//  - On frame=1: collision_mask <= acc (including this cycle's hits), collision_valid <= 1 next cycle.
//    acc is then cleared to 0, so hits in the frame cycle land in the old frame only.
//  - collision_valid is high exactly one cycle per frame pulse. Back-to-back frame pulses give 2 pulses;
//    the second mask holds only hits from the intervening cycle(s).
//  - collision_mask holds its value between frame pulses.
//  - Reset (async assert, any time, incl. mid-frame):
//    screen_pix=0, screen_layer=NUM_LAYERS, collision_mask=0, collision_valid=0, acc=0.
//    After release, the first frame pulse reports only hits seen since release.
//  - layer_en changes take effect on the next cycle's composition; they do not retro-clear acc.
//  - NUM_LAYERS=1: collisions never flagged; mask stays 0, valid still pulses per frame.
// STRUCTURE
//  - Shared package (gfx_pkg): PIX_W/color-code typedef, TRANSPARENT constant, BG layer index helper;
//    color_mapper and sprite use the same package.
//  - Sub-module layer_priority_enc (combinational):
//    in: opaque[NUM_LAYERS]; out: found, index, multi (>=2 set).
//    Top holds the output regs and the collision accumulator.
// TESTING
//  1 NUM_LAYERS=4, layers 1,3 drawing pix 5,9, en=4'hF
//    -> next cycle screen_pix=5, screen_layer=1.
//  2 layer 0 drawing pix=0 (TRANSPARENT) over layer 2 pix=7
//    -> screen_pix=7, screen_layer=2; no collision recorded.
//  3 de=1 cycle with layers 0,2 opaque, then frame
//    -> collision_valid pulse 1 cycle later, collision_mask=4'b0101; next frame with no overlap -> mask=0.
//  4 overlap only while de=0, or with layer_en[2]=0
//    -> next frame mask=0; screen_layer follows en (disabled layer never wins).
//  5 overlap on same cycle as frame
//    -> counted in the mask reported by that pulse; following frame reports 0.
//  6 rst asserted mid-frame after overlap, released, then frame
//    -> outputs 0/NUM_LAYERS during reset, mask=0 on pulse; no layers drawing -> screen_pix=bg_pix.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics types for sprite, sprite_layer_mux and color_mapper:
// color-code width, the see-through code and the background layer index.
package gfx_pkg;
    localparam int COLOR_W = 4;
    typedef logic [COLOR_W-1:0] color_t;
    localparam int TRANSPARENT_CODE = 0;

    // Layer index reported when no sprite layer wins (background).
    function automatic int bg_layer_idx(input int num_layers);
        return num_layers;
    endfunction

    function automatic int layer_idx_w(input int num_layers);
        return $clog2(num_layers + 1);
    endfunction
endpackage

// File: rtl/sprite_layer_mux_if.sv
// Pixel bus between the sprite generators / display timing and the layer compositor.
interface sprite_layer_mux_if #(
    parameter int NUM_LAYERS = 4,
    parameter int PIX_W      = 4
);
    localparam int IDX_W = $clog2(NUM_LAYERS + 1);

    logic                        frame;
    logic                        de;
    logic [NUM_LAYERS-1:0]       layer_en;
    logic [NUM_LAYERS-1:0]       layer_drawing;
    logic [NUM_LAYERS*PIX_W-1:0] layer_pix;
    logic [PIX_W-1:0]            bg_pix;
    logic [PIX_W-1:0]            screen_pix;
    logic [IDX_W-1:0]            screen_layer;
    logic [NUM_LAYERS-1:0]       collision_mask;
    logic                        collision_valid;

    modport master (
        output frame, de, layer_en, layer_drawing, layer_pix, bg_pix,
        input  screen_pix, screen_layer, collision_mask, collision_valid
    );

    modport slave (
        input  frame, de, layer_en, layer_drawing, layer_pix, bg_pix,
        output screen_pix, screen_layer, collision_mask, collision_valid
    );
endinterface

// File: rtl/layer_priority_enc.sv
// Combinational priority encoder over the opaque-layer vector: lowest set
// index wins; multi flags two or more opaque layers (a collision candidate).
module layer_priority_enc #(
    parameter int NUM_LAYERS = 4,
    localparam int IDX_W     = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS-1:0] opaque,
    output logic                  found,
    output logic [IDX_W-1:0]      index,
    output logic                  multi
);
    always_comb begin
        found = |opaque;
        index = IDX_W'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) index = IDX_W'(i);
        end
        // Clearing the lowest set bit leaves something only if >= 2 bits were set.
        multi = |(opaque & (opaque - NUM_LAYERS'(1)));
    end
endmodule

// File: rtl/sprite_layer_mux.sv
// N-layer sprite compositor: registered priority mux with transparency and
// per-layer enables, plus per-frame collision flags for game logic.
module sprite_layer_mux
    import gfx_pkg::*;
#(
    parameter int NUM_LAYERS  = 4,
    parameter int PIX_W       = COLOR_W,
    parameter int TRANSPARENT = TRANSPARENT_CODE
) (
    input  logic               clk_pix,
    input  logic               rst,
    sprite_layer_mux_if.slave  bus
);
    localparam int IDX_W = layer_idx_w(NUM_LAYERS);
    localparam logic [IDX_W-1:0] BG_IDX = IDX_W'(bg_layer_idx(NUM_LAYERS));

    logic [NUM_LAYERS-1:0] opaque;
    logic                  found;
    logic                  multi;
    logic [IDX_W-1:0]      win_idx;
    logic [PIX_W-1:0]      win_pix;
    logic [NUM_LAYERS-1:0] hits;

    logic [PIX_W-1:0]      screen_pix_d,   screen_pix_q;
    logic [IDX_W-1:0]      screen_layer_d, screen_layer_q;
    logic [NUM_LAYERS-1:0] acc_d,          acc_q;
    logic [NUM_LAYERS-1:0] mask_d,         mask_q;
    logic                  valid_d,        valid_q;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_opaque
        assign opaque[g] = bus.layer_en[g] & bus.layer_drawing[g] &
                           (bus.layer_pix[g*PIX_W +: PIX_W] != PIX_W'(TRANSPARENT));
    end

    layer_priority_enc #(.NUM_LAYERS(NUM_LAYERS)) u_enc (
        .opaque (opaque),
        .found  (found),
        .index  (win_idx),
        .multi  (multi)
    );

    always_comb begin
        win_pix = bus.bg_pix;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (found && win_idx == IDX_W'(i)) win_pix = bus.layer_pix[i*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        screen_pix_d   = win_pix;
        screen_layer_d = win_idx;
        hits           = (bus.de && multi) ? opaque : '0;
        // A frame pulse closes the old frame including its own hits, then restarts clean.
        acc_d          = bus.frame ? '0 : (acc_q | hits);
        mask_d         = bus.frame ? (acc_q | hits) : mask_q;
        valid_d        = bus.frame;
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            screen_pix_q   <= '0;
            screen_layer_q <= BG_IDX;
            acc_q          <= '0;
            mask_q         <= '0;
            valid_q        <= 1'b0;
        end else begin
            screen_pix_q   <= screen_pix_d;
            screen_layer_q <= screen_layer_d;
            acc_q          <= acc_d;
            mask_q         <= mask_d;
            valid_q        <= valid_d;
        end
    end

    assign bus.screen_pix      = screen_pix_q;
    assign bus.screen_layer    = screen_layer_q;
    assign bus.collision_mask  = mask_q;
    assign bus.collision_valid = valid_q;
endmodule
